// File: rtl/mem_bus_arbiter_if.sv
// Request/response bundle between the two requesters, the arbiter and ROM/RAM.
// slave = arbiter view, master = requester/memory view.
interface mem_bus_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [DW-1:0] mem_rdata;
  logic          gnt0;
  logic          gnt1;
  logic          done0;
  logic          done1;
  logic          err;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          ram_ena;
  logic          ram_read;
  logic          ram_write;
  logic          rom_ena;
  logic          rom_read;

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  mem_rdata,
    output gnt0, gnt1, done0, done1, err,
    output rdata, mem_addr, mem_wdata,
    output ram_ena, ram_read, ram_write,
    output rom_ena, rom_read
  );

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output mem_rdata,
    input  gnt0, gnt1, done0, done1, err,
    input  rdata, mem_addr, mem_wdata,
    input  ram_ena, ram_read, ram_write,
    input  rom_ena, rom_read
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter and four-phase ROM/RAM access sequencer.
// Ports: clk, rst (async, active-high), bus (slave modport of mem_bus_arbiter_if).
module mem_bus_arbiter #(
  parameter int            AW      = 8,
  parameter int            DW      = 8,
  parameter logic [AW-1:0] ROM_TOP = 'h7F
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_bus_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          owner_q;
  logic          owner_d;
  logic          we_q;
  logic          we_d;
  logic          last_q;
  logic          last_d;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] wdata_d;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  logic cand0;
  logic cand1;
  logic win;
  logic busy;
  logic in_addr;
  logic in_resp;
  logic is_rom;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // The requester being completed in RESP may not win that same arbitration.
  always_comb begin
    in_resp = (state_q == S_RESP);
    cand0   = bus.req0 && !(in_resp && !owner_q);
    cand1   = bus.req1 && !(in_resp && owner_q);
    win     = (cand0 && cand1) ? ~last_q : cand1;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        if (cand0 || cand1) begin
          state_d = S_ADDR;
          owner_d = win;
          last_d  = win;
          we_d    = win ? bus.we1 : bus.we0;
          addr_d  = win ? bus.addr1 : bus.addr0;
          wdata_d = win ? bus.wdata1 : bus.wdata0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: state_d = S_DATA;
      S_DATA: begin
        state_d = S_RESP;
        if (!we_q) rdata_d = bus.mem_rdata;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == S_ADDR) || (state_q == S_DATA);
    in_addr = (state_q == S_ADDR);
    is_rom  = (addr_q <= ROM_TOP);

    bus.gnt0  = busy && !owner_q;
    bus.gnt1  = busy && owner_q;
    bus.done0 = in_resp && !owner_q;
    bus.done1 = in_resp && owner_q;
    // ROM writes are dropped silently on the bus and flagged at completion.
    bus.err   = in_resp && we_q && is_rom;

    bus.rom_ena   = busy && is_rom && !we_q;
    bus.rom_read  = busy && is_rom && !we_q;
    bus.ram_ena   = busy && !is_rom;
    bus.ram_read  = busy && !is_rom && !we_q;
    bus.ram_write = in_addr && !is_rom && we_q;

    bus.mem_addr  = busy ? addr_q : '0;
    bus.mem_wdata = busy ? wdata_q : '0;
    bus.rdata     = rdata_q;
  end

endmodule
